// File: rtl/cache_fill_pkg.sv
// Shared definitions for the cache line fill controller.
// Holds the FSM state encoding and the default geometry constants.
// No logic; imported by the controller and its counter sub-module.
package cache_fill_pkg;

    // Default geometry: 16-bit byte addresses, 8 words of 2 bytes per line
    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int DEF_WORD_BYTES     = 2;

    // Fill FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/cache_fill_wrap_counter.sv
// Clearable, enabled word counter with a wrapped line index output.
// Latency: count updates on the clock edge after i_en/i_clr; index is combinational.
// Backpressure: none of its own; the caller gates i_en (stall, FSM state).
module cache_fill_wrap_counter
    import cache_fill_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_offset,
    output logic [CNT_W-1:0] o_count,
    output logic [IDX_W-1:0] o_index
);

    logic [CNT_W-1:0] r_cnt;

    // Count events; clear has priority so a new fill always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_count = r_cnt;
    // Truncation to IDX_W bits gives the modulo-line-size wrap for free
    assign o_index = i_offset + r_cnt[IDX_W-1:0];

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Cache line fill controller: issues one line's word reads and writes returned words.
// Latency: mem_req in the first FILL cycle after the miss; fill_done one cycle after the last write.
// Backpressure: stall freezes issue and write progress; optional CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_line_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int WORD_BYTES     = DEF_WORD_BYTES
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              miss_detected,
    input  logic [ADDR_W-1:0]                 miss_address,
    input  logic                              stall,
    input  logic                              mem_data_valid,
    output logic                              fsm_busy,
    output logic                              mem_req,
    output logic [ADDR_W-1:0]                 mem_address,
    output logic                              wen_cache,
    output logic [$clog2(WORDS_PER_LINE)-1:0] word_enable,
    output logic                              wen_tag,
    output logic                              fill_done,
    output logic                              critical_word_valid
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int CNT_W = IDX_W + 1;
    localparam int WB_W  = $clog2(WORD_BYTES);
    localparam int OFF_W = IDX_W + WB_W;
    // Byte-offset bits within a line; cleared to form the line base
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_LINE - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_start;
    logic [IDX_W-1:0]  w_start_nxt;
    logic              w_accept;
    logic              w_in_fill;
    logic              w_issue_en;
    logic              w_wen;
    logic              w_last_write;
    logic [CNT_W-1:0]  w_issue_cnt;
    logic [IDX_W-1:0]  w_issue_idx;
    logic [CNT_W-1:0]  w_rcv_cnt;
    logic [IDX_W-1:0]  w_rcv_idx;

    assign w_in_fill = (r_state == ST_FILL);
    // A miss is only taken from IDLE; misses seen while busy are dropped
    assign w_accept  = (r_state == ST_IDLE) && miss_detected;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    // Start at the missed word so the requester's word returns first
    assign w_start_nxt = miss_address[OFF_W-1:WB_W];
`else
    assign w_start_nxt = '0;
`endif

    // Issue while filling, not stalled, and words remain to be requested
    assign w_issue_en   = w_in_fill && !stall && (w_issue_cnt < CNT_FULL);
    // Returned data is only accepted in FILL and never while stalled
    assign w_wen        = w_in_fill && mem_data_valid && !stall;
    assign w_last_write = w_wen && (w_rcv_cnt == CNT_LAST);

    // Latch the line base and start word when a miss is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base  <= '0;
            r_start <= '0;
        end else if (w_accept) begin
            r_base  <= miss_address & ~LINE_MASK;
            r_start <= w_start_nxt;
        end
    end

    // Next-state: IDLE -> FILL on miss, FILL -> COMMIT on the last write, COMMIT lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_FILL;
            ST_FILL:   if (w_last_write) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any fill in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    cache_fill_wrap_counter #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_issue_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept),
        .i_en     (w_issue_en),
        .i_offset (r_start),
        .o_count  (w_issue_cnt),
        .o_index  (w_issue_idx)
    );

    cache_fill_wrap_counter #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_rcv_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept),
        .i_en     (w_wen),
        .i_offset (r_start),
        .o_count  (w_rcv_cnt),
        .o_index  (w_rcv_idx)
    );

    // rst_n gates busy so a miss presented during reset does not show as busy
    assign fsm_busy    = rst_n && ((r_state != ST_IDLE) || miss_detected);
    assign mem_req     = w_issue_en;
    // Address wraps at 2^ADDR_W; holds its value while stalled since the count is frozen
    assign mem_address = r_base + (ADDR_W'(w_issue_idx) << WB_W);
    assign wen_cache   = w_wen;
    assign word_enable = w_rcv_idx;
    assign wen_tag     = (r_state == ST_COMMIT);
    assign fill_done   = (r_state == ST_COMMIT);

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign critical_word_valid = w_wen && (w_rcv_cnt == '0);
`else
    assign critical_word_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Randomized scoreboard bench for cache_line_fill_ctrl.
// Stimulus pushes expected issue addresses / write indices; a negedge monitor pops and compares.
// Covers linear and critical-first order, stalls, reset abort, held misses and stray data valids.
module tb_cache_line_fill_ctrl;

    localparam int W  = 8;
    localparam int WB = 2;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        stall;
    logic        mem_data_valid;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] mem_address;
    logic        wen_cache;
    logic [2:0]  word_enable;
    logic        wen_tag;
    logic        fill_done;
    logic        critical_word_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_addr[$];
    int          exp_we[$];
    bit          exp_crit[$];
    bit          exp_commit = 1'b0;
    bit          chk_frozen = 1'b0;

    cache_line_fill_ctrl #(
        .ADDR_W         (16),
        .WORDS_PER_LINE (W),
        .WORD_BYTES     (WB)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .miss_detected       (miss_detected),
        .miss_address        (miss_address),
        .stall               (stall),
        .mem_data_valid      (mem_data_valid),
        .fsm_busy            (fsm_busy),
        .mem_req             (mem_req),
        .mem_address         (mem_address),
        .wen_cache           (wen_cache),
        .word_enable         (word_enable),
        .wen_tag             (wen_tag),
        .fill_done           (fill_done),
        .critical_word_valid (critical_word_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: samples outputs on the falling edge, inputs change just after the rising edge
    always @(negedge clk) begin
        if (chk_frozen) begin
            check("stall_no_req", int'(mem_req), 0);
            check("stall_no_wen", int'(wen_cache), 0);
            if (exp_addr.size() > 0) check("stall_addr_hold", int'(mem_address), int'(exp_addr[0]));
        end
        if (mem_req) begin
            if (exp_addr.size() == 0) check("issue_unexpected", int'(mem_address), -1);
            else check("issue_addr", int'(mem_address), int'(exp_addr.pop_front()));
        end
        if (wen_cache) begin
            if (exp_we.size() == 0) begin
                check("write_unexpected", int'(word_enable), -1);
            end else begin
                check("word_enable", int'(word_enable), exp_we.pop_front());
                check("critical_word_valid", int'(critical_word_valid), int'(exp_crit.pop_front()));
            end
        end else if (critical_word_valid) begin
            check("crit_without_write", int'(critical_word_valid), int'(wen_cache));
        end
        if (fill_done || wen_tag || exp_commit) begin
            check("fill_done", int'(fill_done), int'(exp_commit));
            check("wen_tag", int'(wen_tag), int'(exp_commit));
        end
    end

    // Reference: expected issue addresses and write indices for a line fill
    task automatic push_expect(input logic [15:0] addr);
        logic [15:0] base;
        int start, idx;
        base  = addr & ~16'(W * WB - 1);
        start = CWF ? (int'(addr) / WB) % W : 0;
        exp_addr.delete();
        exp_we.delete();
        exp_crit.delete();
        for (int i = 0; i < W; i++) begin
            idx = (start + i) % W;
            exp_addr.push_back(16'(int'(base) + idx * WB));
            exp_we.push_back(idx);
            exp_crit.push_back(CWF && (i == 0));
        end
    endtask

    // Idle cycles with stray data valids that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            miss_detected  = 1'b0;
            mem_data_valid = 1'($urandom_range(0, 1));
            stall          = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // One fill. Entered and left 1 time unit after a rising edge.
    // mode 0: valid every cycle; 1: random valid/stall; 2: 3-cycle stall after 3rd write.
    // hold keeps miss high throughout; abort_after>0 resets after that many writes.
    task automatic do_fill(input logic [15:0] addr, input int mode, input bit hold, input int abort_after);
        int writes, cyc, stall_cnt;
        bit s, v;
        push_expect(addr);
        miss_detected  = 1'b1;
        miss_address   = addr;
        mem_data_valid = 1'($urandom_range(0, 1));
        stall          = 1'($urandom_range(0, 1));
        #1 check("busy_on_miss", int'(fsm_busy), 1);
        @(posedge clk); #1;
        writes = 0; cyc = 0; stall_cnt = 0;
        while (writes < W) begin
            if (cyc > 300) begin
                check("fill_timeout_writes", writes, W);
                break;
            end
            cyc++;
            miss_detected = hold;
            miss_address  = 16'($urandom_range(0, 65535));
            case (mode)
                0: begin s = 1'b0; v = 1'b1; end
                1: begin s = ($urandom_range(0, 3) == 0); v = ($urandom_range(0, 2) != 0); end
                default: begin
                    s = (writes == 3) && (stall_cnt < 3);
                    v = 1'b1;
                    if (s) stall_cnt++;
                end
            endcase
            stall          = s;
            mem_data_valid = v;
            chk_frozen     = (mode == 2) && s;
            if (!s && v) writes++;
            @(posedge clk); #1;
            if (abort_after > 0 && writes == abort_after) begin
                chk_frozen     = 1'b0;
                rst_n          = 1'b0;
                miss_detected  = 1'b1;
                mem_data_valid = 1'b1;
                stall          = 1'b0;
                #1 check("reset_abort_outputs",
                         int'({fsm_busy, mem_req, mem_address, wen_cache, word_enable,
                               wen_tag, fill_done, critical_word_valid}), 0);
                exp_addr.delete();
                exp_we.delete();
                exp_crit.delete();
                @(posedge clk); #1;
                rst_n         = 1'b1;
                miss_detected = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        chk_frozen = 1'b0;
        // Commit cycle: stall and stray valids must not extend or disturb it
        check("all_words_issued", exp_addr.size(), 0);
        exp_commit     = 1'b1;
        miss_detected  = hold;
        stall          = 1'($urandom_range(0, 1));
        mem_data_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        exp_commit = 1'b0;
        if (!hold) begin
            miss_detected  = 1'b0;
            stall          = 1'($urandom_range(0, 1));
            mem_data_valid = 1'($urandom_range(0, 1));
            #1 check("busy_after_commit", int'(fsm_busy), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        miss_detected  = 1'b1;
        miss_address   = 16'h1234;
        stall          = 1'b0;
        mem_data_valid = 1'b1;
        #2 check("reset_outputs",
                 int'({fsm_busy, mem_req, mem_address, wen_cache, word_enable,
                       wen_tag, fill_done, critical_word_valid}), 0);
        miss_detected = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_fill(16'h1234, 0, 1'b0, 0);
        idle(2);
        do_fill(16'h1234, 2, 1'b0, 0);
        do_fill(16'h5678, 0, 1'b0, 4);
        idle(1);
        do_fill(16'hFFF6, 0, 1'b0, 0);
        do_fill(16'h0100, 0, 1'b1, 0);
        do_fill(16'h2222, 1, 1'b1, 0);
        do_fill(16'h3336, 1, 1'b0, 0);
        idle(3);
        for (int i = 0; i < 24; i++) begin
            bit h;
            h = (i != 23) && ($urandom_range(0, 3) == 0);
            do_fill(16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)) == 0 ? 0 : 1, h, 0);
            if (!h) idle(int'($urandom_range(0, 3)));
        end
        idle(2);
        check("leftover_expect", exp_addr.size() + exp_we.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_line_fill_ctrl.md
CACHE_LINE_FILL_CTRL -- requirements
Module: cache_line_fill_ctrl

Interface
REQ-001 Parameter ADDR_W, 16, byte-address width.
REQ-002 Parameter WORDS_PER_LINE, 8, words per cache line; SHALL be a power of two, at least 2.
REQ-003 Parameter WORD_BYTES, 2, bytes per word; SHALL be a power of two.
REQ-004 Port clk, input, 1, sole clock, rising edge.
REQ-005 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port miss_detected, input, 1, cache miss request.
REQ-007 Port miss_address, input, ADDR_W, byte address that missed.
REQ-008 Port stall, input, 1, freezes all fill progress.
REQ-009 Port mem_data_valid, input, 1, one in-order memory word returned this cycle.
REQ-010 Port fsm_busy, output, 1, fill in progress or starting.
REQ-011 Port mem_req, output, 1, issue strobe for mem_address.
REQ-012 Port mem_address, output, ADDR_W, word address being issued.
REQ-013 Port wen_cache, output, 1, data-array write enable.
REQ-014 Port word_enable, output, log2(WORDS_PER_LINE), line word index being written.
REQ-015 Port wen_tag, output, 1, tag/valid write enable.
REQ-016 Port fill_done, output, 1, one-cycle completion pulse.
REQ-017 Port critical_word_valid, output, 1, first returned word is being written.

Function
REQ-018 States SHALL be IDLE, FILL and COMMIT.
REQ-019 IDLE with miss_detected=1 SHALL go to FILL; the line base (miss_address with low log2(WORDS_PER_LINE*WORD_BYTES) bits cleared) and the start index SHALL be latched; issue and receive counts SHALL clear.
REQ-020 fsm_busy SHALL equal (state != IDLE) OR (state == IDLE AND miss_detected).
REQ-021 In FILL with stall=0 and issue count < WORDS_PER_LINE, mem_req SHALL be 1 and mem_address SHALL be base + ((start + issue count) mod WORDS_PER_LINE) * WORD_BYTES; issue count SHALL increment each such cycle.
REQ-022 mem_req SHALL be 0 outside FILL, when stall=1, or once all words have been issued.
REQ-023 In FILL, wen_cache SHALL equal mem_data_valid AND NOT stall, with word_enable = (start + receive count) mod WORDS_PER_LINE.
REQ-024 Receive count SHALL increment on each wen_cache.
REQ-025 mem_data_valid during stall SHALL be ignored: no write and no count change.
REQ-026 The write at receive count WORDS_PER_LINE-1 SHALL move the FSM to COMMIT on the next cycle.
REQ-027 COMMIT SHALL last exactly one cycle, with wen_tag=1 and fill_done=1; it SHALL then return to IDLE, and stall SHALL NOT extend it.
REQ-028 miss_detected outside IDLE SHALL be ignored; a new miss is accepted only from IDLE, the cycle after COMMIT at the earliest.
REQ-029 mem_data_valid outside FILL SHALL be ignored.
REQ-030 Counters SHALL be log2(WORDS_PER_LINE)+1 bits; index arithmetic SHALL wrap modulo WORDS_PER_LINE; address addition SHALL wrap modulo 2^ADDR_W.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and set every output and internal register to 0, including mem_address and the latched base.
REQ-032 Reset during FILL or COMMIT SHALL abort the fill with no wen_tag and no fill_done.

Configuration
REQ-033 With CACHE_FILL_CRITICAL_WORD_FIRST_EN defined, the start index SHALL be the missed word's offset within the line, and critical_word_valid SHALL pulse with the first wen_cache of each fill.
REQ-034 Without CACHE_FILL_CRITICAL_WORD_FIRST_EN, the start index SHALL be 0 and critical_word_valid SHALL be tied to 0.

Structure
REQ-035 Package cache_fill_pkg SHALL hold the state encoding and the default parameter constants.
REQ-036 A sub-module cache_fill_wrap_counter, implementing a clearable, enabled counter with a wrapped index output, SHALL be instantiated twice: once for issue, once for receive.

Verification (defaults: 16-bit address, 8 words per line, 2 bytes per word)
REQ-037 Macro off, miss at 0x1234, valid every cycle -> mem_address 0x1230,0x1232,...,0x123E; word_enable 0..7; wen_tag and fill_done one cycle after the 8th write; busy low the next cycle.
REQ-038 Macro on, miss at 0x1234 -> issue order 0x1234,...,0x123E,0x1230,0x1232; word_enable 2,3,...,7,0,1; critical_word_valid only on the write of word 2.
REQ-039 stall=1 for 3 cycles mid-fill with valid held high -> mem_address and counts frozen, no wen_cache; the fill resumes at the same index and still writes exactly 8 words.
REQ-040 rst_n low after the 4th write -> all outputs 0 within the same cycle, no wen_tag; a new miss at 0xFFF6 then fills 0xFFF0..0xFFFE with no wrap error.
REQ-041 miss_detected held high through a fill, plus valid pulses in COMMIT and IDLE -> exactly one fill, no extra writes, the next fill starts the cycle after COMMIT.
